// File: rtl/sd_spi_arb_pkg.sv
// Shared types and pad index constants for the SD/SPI pad arbiter.
package sd_spi_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_SD   = 2'b01,
    OWN_SPI  = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_SD  = 2'd1,
    GNT_SPI = 2'd2,
    TURN    = 2'd3
  } arb_state_e;

  localparam int SPI_CS_DAT_IDX   = 3;
  localparam int SPI_MISO_DAT_IDX = 0;

endpackage

// File: rtl/sd_spi_pad_mux.sv
// Combinational pad and return-path steering for the SD pad group, keyed by owner.
module sd_spi_pad_mux
  import sd_spi_arb_pkg::*;
(
  input  logic [1:0] owner_i,
  input  logic       sd_sclk_i,
  input  logic       sd_cmd_o_i,
  input  logic       sd_cmd_oe_i,
  input  logic [3:0] sd_dat_o_i,
  input  logic [3:0] sd_dat_oe_i,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_csn_i,
  input  logic       pad_cmd_i,
  input  logic [3:0] pad_dat_i,
  output logic       pad_sclk_o,
  output logic       pad_cmd_o,
  output logic       pad_cmd_oe_o,
  output logic [3:0] pad_dat_o,
  output logic [3:0] pad_dat_oe_o,
  output logic       sd_cmd_i_o,
  output logic [3:0] sd_dat_i_o,
  output logic       spi_miso_o
);

  always_comb begin
    // Unowned: every pad released and low, return paths parked high (bus idle level)
    pad_sclk_o   = 1'b0;
    pad_cmd_o    = 1'b0;
    pad_cmd_oe_o = 1'b0;
    pad_dat_o    = 4'b0000;
    pad_dat_oe_o = 4'b0000;
    sd_cmd_i_o   = 1'b1;
    sd_dat_i_o   = 4'b1111;
    spi_miso_o   = 1'b1;
    case (owner_i)
      OWN_SD: begin
        pad_sclk_o   = sd_sclk_i;
        pad_cmd_o    = sd_cmd_o_i;
        pad_cmd_oe_o = sd_cmd_oe_i;
        pad_dat_o    = sd_dat_o_i;
        pad_dat_oe_o = sd_dat_oe_i;
        sd_cmd_i_o   = pad_cmd_i;
        sd_dat_i_o   = pad_dat_i;
      end
      OWN_SPI: begin
        pad_sclk_o                   = spi_sclk_i;
        pad_cmd_o                    = spi_mosi_i;
        pad_cmd_oe_o                 = 1'b1;
        pad_dat_o[SPI_CS_DAT_IDX]    = spi_csn_i;
        pad_dat_oe_o[SPI_CS_DAT_IDX] = 1'b1;
        spi_miso_o                   = pad_dat_i[SPI_MISO_DAT_IDX];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sd_spi_pin_arbiter.sv
// Round-robin transaction arbiter for the shared SD pads (SD host vs SPI master).
// Optional grant-length watchdog enabled by defining SD_SPI_ARB_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | no owner, pads released, evaluating requests
//   GNT_SD  | SD host owns the pads
//   GNT_SPI | SPI master owns the pads
//   TURN    | pads released, counting the turnaround gap
module sd_spi_pin_arbiter
  import sd_spi_arb_pkg::*;
#(
  parameter int TURNAROUND_CYCLES = 4,
  parameter int TIMEOUT_CYCLES    = 65536,
  parameter int CNT_W             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sd_req_i,
  input  logic       spi_req_i,
  input  logic       sd_done_i,
  input  logic       spi_done_i,
  output logic       sd_gnt_o,
  output logic       spi_gnt_o,
  input  logic       sd_sclk_i,
  input  logic       sd_cmd_o_i,
  input  logic       sd_cmd_oe_i,
  input  logic [3:0] sd_dat_o_i,
  input  logic [3:0] sd_dat_oe_i,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_csn_i,
  output logic       pad_sclk_o,
  output logic       pad_cmd_o,
  output logic       pad_cmd_oe_o,
  output logic [3:0] pad_dat_o,
  output logic [3:0] pad_dat_oe_o,
  input  logic       pad_cmd_i,
  input  logic [3:0] pad_dat_i,
  output logic       sd_cmd_i_o,
  output logic [3:0] sd_dat_i_o,
  output logic       spi_miso_o,
  output logic [1:0] owner_o,
  output logic       timeout_o
);

  localparam logic [1:0] S_IDLE    = IDLE;
  localparam logic [1:0] S_GNT_SD  = GNT_SD;
  localparam logic [1:0] S_GNT_SPI = GNT_SPI;
  localparam logic [1:0] S_TURN    = TURN;

  logic [1:0]       state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sd_gnt_q, spi_gnt_q;
  logic             timeout_d;
  logic             sd_win, spi_win, pick, rel;

  // Tie goes to whoever did not own the pads last
  assign sd_win  = sd_req_i && (!spi_req_i || (last_q == OWN_SPI));
  assign spi_win = spi_req_i && !sd_win;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    pick      = 1'b0;
    rel       = 1'b0;
    case (state_q)
      S_IDLE: pick = 1'b1;
      S_GNT_SD: begin
        if (sd_done_i || !sd_req_i) rel = 1'b1;
`ifdef SD_SPI_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
`endif
      end
      S_GNT_SPI: begin
        if (spi_done_i || !spi_req_i) rel = 1'b1;
`ifdef SD_SPI_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rel       = 1'b1;
          timeout_d = 1'b1;
        end else cnt_d = cnt_q + CNT_W'(1);
`endif
      end
      S_TURN: begin
        if (cnt_q == '0) pick = 1'b1;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (rel) begin
      state_d = S_TURN;
      owner_d = OWN_NONE;
      cnt_d   = CNT_W'(TURNAROUND_CYCLES);
    end

    if (pick) begin
      cnt_d = '0;
      if (sd_win) begin
        state_d = S_GNT_SD;
        owner_d = OWN_SD;
        last_d  = OWN_SD;
      end else if (spi_win) begin
        state_d = S_GNT_SPI;
        owner_d = OWN_SPI;
        last_d  = OWN_SPI;
      end else begin
        state_d = S_IDLE;
        owner_d = OWN_NONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      last_q    <= OWN_SPI;
      cnt_q     <= '0;
      sd_gnt_q  <= 1'b0;
      spi_gnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      sd_gnt_q  <= (state_d == S_GNT_SD);
      spi_gnt_q <= (state_d == S_GNT_SPI);
    end
  end

`ifdef SD_SPI_ARB_TIMEOUT_EN
  logic timeout_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) timeout_q <= 1'b0;
    else         timeout_q <= timeout_d;
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign sd_gnt_o  = sd_gnt_q;
  assign spi_gnt_o = spi_gnt_q;
  assign owner_o   = owner_q;

  sd_spi_pad_mux u_pad_mux (
    .owner_i      (owner_q),
    .sd_sclk_i    (sd_sclk_i),
    .sd_cmd_o_i   (sd_cmd_o_i),
    .sd_cmd_oe_i  (sd_cmd_oe_i),
    .sd_dat_o_i   (sd_dat_o_i),
    .sd_dat_oe_i  (sd_dat_oe_i),
    .spi_sclk_i   (spi_sclk_i),
    .spi_mosi_i   (spi_mosi_i),
    .spi_csn_i    (spi_csn_i),
    .pad_cmd_i    (pad_cmd_i),
    .pad_dat_i    (pad_dat_i),
    .pad_sclk_o   (pad_sclk_o),
    .pad_cmd_o    (pad_cmd_o),
    .pad_cmd_oe_o (pad_cmd_oe_o),
    .pad_dat_o    (pad_dat_o),
    .pad_dat_oe_o (pad_dat_oe_o),
    .sd_cmd_i_o   (sd_cmd_i_o),
    .sd_dat_i_o   (sd_dat_i_o),
    .spi_miso_o   (spi_miso_o)
  );

endmodule
